// File: rtl/vga_capture_if.sv
// rtl/vga_capture_if.sv - signal bundle between a VGA source and vga_capture
//
// Source side : _hSync, _vSync (active low), rIn/gIn/bIn (4b colour).
// Capture side: locked, isVisible, x/y (10b), r/g/b (4b), frameStart,
//               hTotal/vTotal (10b), frameCount (16b), errorCount (8b).
// master = the source / observer, slave = vga_capture.
interface vga_capture_if;
    logic        _hSync;
    logic        _vSync;
    logic [3:0]  rIn;
    logic [3:0]  gIn;
    logic [3:0]  bIn;
    logic        locked;
    logic        isVisible;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;
    logic        frameStart;
    logic [9:0]  hTotal;
    logic [9:0]  vTotal;
    logic [15:0] frameCount;
    logic [7:0]  errorCount;

    modport master (
        output _hSync, _vSync, rIn, gIn, bIn,
        input  locked, isVisible, x, y, r, g, b, frameStart,
               hTotal, vTotal, frameCount, errorCount
    );

    modport slave (
        input  _hSync, _vSync, rIn, gIn, bIn,
        output locked, isVisible, x, y, r, g, b, frameStart,
               hTotal, vTotal, frameCount, errorCount
    );
endinterface

// File: rtl/vga_capture.sv
// rtl/vga_capture.sv - VGA timing lock detector and active-area pixel capture
//
// Ports: clk (pixel clock), _reset (async active-low), vga (vga_capture_if.slave:
// syncs and colour in; lock status, coordinates, captured pixel, measured
// timing and statistics out).
// Optional feature macro: VGA_CAPTURE_STATS_EN enables frameCount/errorCount;
// without it both read as constant 0.
module vga_capture #(
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int H_VISIBLE = 640,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int V_VISIBLE = 480
) (
    input  logic         clk,
    input  logic         _reset,
    vga_capture_if.slave vga
);
    localparam logic [9:0]  H_START = 10'(H_SYNC + H_BACK);
    localparam logic [10:0] H_END   = 11'(H_SYNC + H_BACK + H_VISIBLE);
    localparam logic [9:0]  V_START = 10'(V_SYNC + V_BACK);
    localparam logic [10:0] V_END   = 11'(V_SYNC + V_BACK + V_VISIBLE);

    typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} state_t;

    state_t      state_q, state_d;
    // [0],[1] synchronizer stages, [2] history for edge detection
    logic [2:0]  hsync_q, vsync_q;
    logic [11:0] pix1_q, pix2_q;
    logic [9:0]  hcount_q, hcount_d;
    logic [9:0]  vcount_q, vcount_d;
    logic [9:0]  htotal_q, htotal_d;
    logic [9:0]  vtotal_q, vtotal_d;
    logic        vis_q, vis_d;
    logic [9:0]  x_q, y_q;
    logic [3:0]  r_q, g_q, b_q;
    logic        frame_start_q;

    logic        h_fall, v_fall, timeout, h_in, v_in;
    logic [9:0]  line_len, frame_len;

    assign h_fall    = hsync_q[2] & ~hsync_q[1];
    assign v_fall    = vsync_q[2] & ~vsync_q[1];
    assign line_len  = hcount_q + 10'd1;
    // A vFall normally lands together with the hFall that closes the last line.
    assign frame_len = vcount_q + {9'd0, h_fall};
    // An arriving hFall restarts the line, so a saturated count is not a timeout then.
    assign timeout   = (hcount_q == 10'h3FF) && !h_fall;
    assign h_in      = (hcount_q >= H_START) && ({1'b0, hcount_q} < H_END);
    assign v_in      = (vcount_q >= V_START) && ({1'b0, vcount_q} < V_END);

    always_comb begin
        hcount_d = (hcount_q == 10'h3FF) ? hcount_q : hcount_q + 10'd1;
        if (h_fall) hcount_d = '0;
        vcount_d = vcount_q;
        if (v_fall)                              vcount_d = '0;
        else if (h_fall && vcount_q != 10'h3FF)  vcount_d = vcount_q + 10'd1;
        vis_d = (state_q == LOCKED) && h_in && v_in;
    end

    always_comb begin
        state_d  = state_q;
        htotal_d = htotal_q;
        vtotal_d = vtotal_q;
        unique case (state_q)
            SEARCH: if (v_fall) state_d = MEASURE;
            MEASURE: begin
                if (h_fall) htotal_d = line_len;
                if (v_fall) begin
                    vtotal_d = frame_len;
                    state_d  = VERIFY;
                end
            end
            VERIFY: begin
                if (h_fall && line_len != htotal_q) begin
                    state_d = MEASURE;
                end else if (v_fall) begin
                    if (frame_len == vtotal_q) state_d = LOCKED;
                    else                       vtotal_d = frame_len;
                end
            end
            LOCKED: begin
                if ((h_fall && line_len != htotal_q) || (v_fall && frame_len != vtotal_q))
                    state_d = SEARCH;
            end
            default: state_d = SEARCH;
        endcase
        if (timeout) state_d = SEARCH;
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state_q       <= SEARCH;
            hsync_q       <= 3'b111;
            vsync_q       <= 3'b111;
            pix1_q        <= '0;
            pix2_q        <= '0;
            hcount_q      <= '0;
            vcount_q      <= '0;
            htotal_q      <= '0;
            vtotal_q      <= '0;
            vis_q         <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            r_q           <= '0;
            g_q           <= '0;
            b_q           <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hsync_q       <= {hsync_q[1:0], vga._hSync};
            vsync_q       <= {vsync_q[1:0], vga._vSync};
            pix1_q        <= {vga.rIn, vga.gIn, vga.bIn};
            pix2_q        <= pix1_q;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            htotal_q      <= htotal_d;
            vtotal_q      <= vtotal_d;
            vis_q         <= vis_d;
            x_q           <= vis_d ? hcount_q - H_START : '0;
            y_q           <= vis_d ? vcount_q - V_START : '0;
            r_q           <= vis_d ? pix2_q[11:8] : '0;
            g_q           <= vis_d ? pix2_q[7:4]  : '0;
            b_q           <= vis_d ? pix2_q[3:0]  : '0;
            frame_start_q <= v_fall;
        end
    end

    assign vga.locked     = (state_q == LOCKED);
    assign vga.isVisible  = vis_q;
    assign vga.x          = x_q;
    assign vga.y          = y_q;
    assign vga.r          = r_q;
    assign vga.g          = g_q;
    assign vga.b          = b_q;
    assign vga.frameStart = frame_start_q;
    assign vga.hTotal     = htotal_q;
    assign vga.vTotal     = vtotal_q;

`ifdef VGA_CAPTURE_STATS_EN
    logic [15:0] frame_count_q;
    logic [7:0]  error_count_q;
    logic        lose_lock;

    // Leaving LOCKED always means SEARCH: a mismatch or a timeout.
    assign lose_lock = (state_q == LOCKED) && (state_d == SEARCH);

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            frame_count_q <= '0;
            error_count_q <= '0;
        end else begin
            if (v_fall && state_q == LOCKED)       frame_count_q <= frame_count_q + 16'd1;
            if (lose_lock && error_count_q != 8'hFF) error_count_q <= error_count_q + 8'd1;
        end
    end

    assign vga.frameCount = frame_count_q;
    assign vga.errorCount = error_count_q;
`else
    assign vga.frameCount = '0;
    assign vga.errorCount = '0;
`endif
endmodule
